id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage core, with the load-use hazard detector built in.
- Captures decoded operands and control from ID each cycle and presents them to EX. It is the source of the RS/RT indices consumed by the forwarding unit.
- Detects a load followed by a dependent instruction. It then stalls IF/ID for one cycle and inserts a bubble into EX.
- Honours branch flush from EX and a global memory stall.

---
 rtl/id_ex_stage_pkg.sv | 23 ++
 rtl/id_ex_stage_hazard_detect.sv | 39 +++
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types and widths for the ID/EX pipeline register and its hazard logic.
//   REGISTER_BITS / DATA_WIDTH / IMM_WIDTH / ALUOP_WIDTH / CNT_WIDTH : default widths
//   ctrl_t      : control bundle carried from ID into EX
//   BUBBLE_CTRL : control bundle of an inserted bubble (no side effects)
package id_ex_stage_pkg;

    localparam int unsigned REGISTER_BITS = 5;
    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned IMM_WIDTH     = 32;
    localparam int unsigned ALUOP_WIDTH   = 4;
    localparam int unsigned CNT_WIDTH     = 16;

    typedef struct packed {
        logic alu_src;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector.
//   i_ex_*     : instruction currently in EX (the potential load)
//   i_id_*     : instruction currently in ID (the potential consumer)
//   i_ex_flush : EX is killing the ID instruction this cycle
//   i_mem_stall: whole pipe frozen by data memory
//   o_load_use_c : raw load-use dependency
//   o_hz_stall_c : hold PC and IF/ID this cycle
module hazard_detect #(
    parameter int unsigned REGISTER_BITS = id_ex_stage_pkg::REGISTER_BITS
) (
    input  logic                     i_ex_valid,
    input  logic                     i_ex_mem_read,
    input  logic [REGISTER_BITS-1:0] i_ex_rd,
    input  logic                     i_id_valid,
    input  logic [REGISTER_BITS-1:0] i_id_rs,
    input  logic [REGISTER_BITS-1:0] i_id_rt,
    input  logic                     i_id_use_rs,
    input  logic                     i_id_use_rt,
    input  logic                     i_ex_flush,
    input  logic                     i_mem_stall,
    output logic                     o_load_use_c,
    output logic                     o_hz_stall_c
);

    logic w_ex_is_load;
    logic w_rs_hit;
    logic w_rt_hit;

    // A load targeting r0 never produces a value anyone waits for.
    assign w_ex_is_load = i_ex_valid & i_ex_mem_read & (i_ex_rd != '0);
    assign w_rs_hit     = i_id_use_rs & (i_id_rs == i_ex_rd);
    assign w_rt_hit     = i_id_use_rt & (i_id_rt == i_ex_rd);

    assign o_load_use_c = w_ex_is_load & i_id_valid & (w_rs_hit | w_rt_hit);

    // Flush kills the consumer; mem_stall already freezes upstream on its own.
    assign o_hz_stall_c = o_load_use_c & ~i_ex_flush & ~i_mem_stall;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with built-in load-use bubble insertion.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   id_*                : decoded instruction from ID
//   ex_flush            : taken branch in EX, replace ID instruction with a bubble
//   mem_stall           : global freeze, every register holds
//   ex_*                : registered ID/EX fields presented to EX / forwarding unit
//   hz_stall            : combinational, hold PC and IF/ID this cycle
//   stall_cnt           : saturating count of load-use bubbles inserted
module id_ex_stage #(
    parameter int unsigned REGISTER_BITS = id_ex_stage_pkg::REGISTER_BITS,
    parameter int unsigned DATA_WIDTH    = id_ex_stage_pkg::DATA_WIDTH,
    parameter int unsigned IMM_WIDTH     = id_ex_stage_pkg::IMM_WIDTH,
    parameter int unsigned ALUOP_WIDTH   = id_ex_stage_pkg::ALUOP_WIDTH,
    parameter int unsigned CNT_WIDTH     = id_ex_stage_pkg::CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [REGISTER_BITS-1:0] id_rs,
    input  logic [REGISTER_BITS-1:0] id_rt,
    input  logic [REGISTER_BITS-1:0] id_rd,
    input  logic                     id_use_rs,
    input  logic                     id_use_rt,
    input  logic [DATA_WIDTH-1:0]    id_rs_data,
    input  logic [DATA_WIDTH-1:0]    id_rt_data,
    input  logic [IMM_WIDTH-1:0]     id_imm,
    input  logic [ALUOP_WIDTH-1:0]   id_alu_op,
    input  logic                     id_alu_src,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     id_mem_to_reg,
    input  logic                     ex_flush,
    input  logic                     mem_stall,
    output logic                     ex_valid,
    output logic [REGISTER_BITS-1:0] ex_rs,
    output logic [REGISTER_BITS-1:0] ex_rt,
    output logic [REGISTER_BITS-1:0] ex_rd,
    output logic [DATA_WIDTH-1:0]    ex_rs_data,
    output logic [DATA_WIDTH-1:0]    ex_rt_data,
    output logic [IMM_WIDTH-1:0]     ex_imm,
    output logic [ALUOP_WIDTH-1:0]   ex_alu_op,
    output logic                     ex_alu_src,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic                     ex_mem_to_reg,
    output logic                     hz_stall,
    output logic [CNT_WIDTH-1:0]     stall_cnt
);

    import id_ex_stage_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                     r_valid;
    logic [REGISTER_BITS-1:0] r_rs;
    logic [REGISTER_BITS-1:0] r_rt;
    logic [REGISTER_BITS-1:0] r_rd;
    logic [DATA_WIDTH-1:0]    r_rs_data;
    logic [DATA_WIDTH-1:0]    r_rt_data;
    logic [IMM_WIDTH-1:0]     r_imm;
    logic [ALUOP_WIDTH-1:0]   r_alu_op;
    ctrl_t                    r_ctrl;
    logic [CNT_WIDTH-1:0]     r_stall_cnt;

    ctrl_t                    w_id_ctrl;
    logic                     w_load_use;
    logic                     w_hz_stall;

    hazard_detect #(
        .REGISTER_BITS (REGISTER_BITS)
    ) u_hazard_detect (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rd       (r_rd),
        .i_id_valid    (id_valid),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_use_rs   (id_use_rs),
        .i_id_use_rt   (id_use_rt),
        .i_ex_flush    (ex_flush),
        .i_mem_stall   (mem_stall),
        .o_load_use_c  (w_load_use),
        .o_hz_stall_c  (w_hz_stall)
    );

    // Incoming control, squashed for an invalid slot; writes to r0 are dropped.
    always_comb begin
        w_id_ctrl            = BUBBLE_CTRL;
        w_id_ctrl.alu_src    = id_valid & id_alu_src;
        w_id_ctrl.reg_write  = id_valid & id_reg_write & (id_rd != '0);
        w_id_ctrl.mem_read   = id_valid & id_mem_read;
        w_id_ctrl.mem_write  = id_valid & id_mem_write;
        w_id_ctrl.mem_to_reg = id_valid & id_mem_to_reg;
    end

    // Pipeline register: hold > flush bubble > load-use bubble > capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_alu_op    <= '0;
            r_ctrl      <= BUBBLE_CTRL;
            r_stall_cnt <= '0;
        end else if (mem_stall) begin
            r_valid     <= r_valid;
        end else if (ex_flush || w_load_use) begin
            r_valid     <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_alu_op    <= '0;
            r_ctrl      <= BUBBLE_CTRL;
            // Only a genuine load-use bubble is counted, never a flush.
            if (!ex_flush && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
        end else begin
            r_valid     <= id_valid;
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            r_rd        <= id_rd;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_alu_op    <= id_alu_op;
            r_ctrl      <= w_id_ctrl;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_rd         = r_rd;
    assign ex_rs_data    = r_rs_data;
    assign ex_rt_data    = r_rt_data;
    assign ex_imm        = r_imm;
    assign ex_alu_op     = r_alu_op;
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign hz_stall      = w_hz_stall;
    assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage (built with a 2-bit stall counter).
module tb_id_ex_stage;

    localparam int unsigned RB = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    typedef struct {
        logic          v;
        logic [RB-1:0] rs, rt, rd;
        logic          urs, urt;
        logic [DW-1:0] rsd, rtd;
        logic [IW-1:0] imm;
        logic [AW-1:0] op;
        logic          as, rw, mr, mw, m2r;
        logic          fl, ms;
    } in_t;

    typedef struct {
        logic          v;
        logic [RB-1:0] rs, rt, rd;
        logic [DW-1:0] rsd, rtd;
        logic [IW-1:0] imm;
        logic [AW-1:0] op;
        logic          as, rw, mr, mw, m2r;
        logic [CW-1:0] cnt;
    } st_t;

    typedef struct {
        logic          v;
        logic [RB-1:0] rs, rt, rd;
        logic          urs, urt, mr, rw, fl, ms;
        logic          e_hz, e_v;
        logic [RB-1:0] e_rd;
        logic          e_rw;
        logic [CW-1:0] e_cnt;
    } vec_t;

    in_t cur;
    st_t m;
    int  checks = 0;
    int  errors = 0;

    logic          ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hz_stall;
    logic [RB-1:0] ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_rs_data, ex_rt_data;
    logic [IW-1:0] ex_imm;
    logic [AW-1:0] ex_alu_op;
    logic [CW-1:0] stall_cnt;

    id_ex_stage #(
        .REGISTER_BITS (RB), .DATA_WIDTH (DW), .IMM_WIDTH (IW),
        .ALUOP_WIDTH (AW), .CNT_WIDTH (CW)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .id_valid (cur.v), .id_rs (cur.rs), .id_rt (cur.rt), .id_rd (cur.rd),
        .id_use_rs (cur.urs), .id_use_rt (cur.urt),
        .id_rs_data (cur.rsd), .id_rt_data (cur.rtd), .id_imm (cur.imm), .id_alu_op (cur.op),
        .id_alu_src (cur.as), .id_reg_write (cur.rw), .id_mem_read (cur.mr),
        .id_mem_write (cur.mw), .id_mem_to_reg (cur.m2r),
        .ex_flush (cur.fl), .mem_stall (cur.ms),
        .ex_valid (ex_valid), .ex_rs (ex_rs), .ex_rt (ex_rt), .ex_rd (ex_rd),
        .ex_rs_data (ex_rs_data), .ex_rt_data (ex_rt_data), .ex_imm (ex_imm), .ex_alu_op (ex_alu_op),
        .ex_alu_src (ex_alu_src), .ex_reg_write (ex_reg_write), .ex_mem_read (ex_mem_read),
        .ex_mem_write (ex_mem_write), .ex_mem_to_reg (ex_mem_to_reg),
        .hz_stall (hz_stall), .stall_cnt (stall_cnt)
    );

    // Reference: a load in EX writing a nonzero register that ID actually reads.
    function automatic logic mdl_lu(st_t s, in_t i);
        return s.v && s.mr && (s.rd != 0) && i.v &&
               ((i.urs && i.rs == s.rd) || (i.urt && i.rt == s.rd));
    endfunction

    function automatic st_t mdl_zero();
        st_t z;
        z = '{v: 1'b0, rs: '0, rt: '0, rd: '0, rsd: '0, rtd: '0, imm: '0, op: '0,
              as: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, cnt: '0};
        return z;
    endfunction

    function automatic st_t mdl_next(st_t s, in_t i);
        st_t n;
        int  c;
        if (i.ms) return s;
        if (i.fl || mdl_lu(s, i)) begin
            n = mdl_zero();
            c = int'(s.cnt);
            if (!i.fl) c = (c + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : c + 1;
            n.cnt = CW'(c);
            return n;
        end
        n     = s;
        n.v   = i.v;   n.rs  = i.rs;  n.rt  = i.rt;  n.rd = i.rd;
        n.rsd = i.rsd; n.rtd = i.rtd; n.imm = i.imm; n.op = i.op;
        n.as  = i.v & i.as;
        n.rw  = i.v & i.rw & (i.rd != 0);
        n.mr  = i.v & i.mr;
        n.mw  = i.v & i.mw;
        n.m2r = i.v & i.m2r;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ex_valid"},   32'(ex_valid),      32'(m.v));
        chk({tag, ".ex_rs"},      32'(ex_rs),         32'(m.rs));
        chk({tag, ".ex_rt"},      32'(ex_rt),         32'(m.rt));
        chk({tag, ".ex_rd"},      32'(ex_rd),         32'(m.rd));
        chk({tag, ".ex_rs_data"}, ex_rs_data,         m.rsd);
        chk({tag, ".ex_rt_data"}, ex_rt_data,         m.rtd);
        chk({tag, ".ex_imm"},     ex_imm,             m.imm);
        chk({tag, ".ex_alu_op"},  32'(ex_alu_op),     32'(m.op));
        chk({tag, ".ctrl"},
            32'({ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
            32'({m.as, m.rw, m.mr, m.mw, m.m2r}));
        chk({tag, ".stall_cnt"},  32'(stall_cnt),     32'(m.cnt));
    endtask

    // One clock: check hz_stall mid-cycle, advance model at the edge, check outputs after.
    task automatic step(input string tag, output logic hz_seen);
        @(negedge clk);
        hz_seen = hz_stall;
        chk({tag, ".hz_stall"}, 32'(hz_stall), 32'(mdl_lu(m, cur) && !cur.fl && !cur.ms));
        @(posedge clk);
        m = mdl_next(m, cur);
        #1;
        chk_all(tag);
    endtask

    function automatic in_t idle_in();
        in_t i;
        i = '{v: 1'b0, rs: '0, rt: '0, rd: '0, urs: 1'b0, urt: 1'b0,
              rsd: $urandom, rtd: $urandom, imm: $urandom, op: AW'($urandom),
              as: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, fl: 1'b0, ms: 1'b0};
        return i;
    endfunction

    function automatic in_t rand_in();
        in_t i;
        i     = idle_in();
        i.v   = ($urandom_range(0, 9) != 0);
        i.rs  = RB'($urandom_range(0, 3));
        i.rt  = RB'($urandom_range(0, 3));
        i.rd  = RB'($urandom_range(0, 3));
        i.urs = 1'($urandom); i.urt = 1'($urandom);
        i.as  = 1'($urandom); i.rw  = 1'($urandom); i.mr = 1'($urandom);
        i.mw  = 1'($urandom); i.m2r = 1'($urandom);
        i.fl  = ($urandom_range(0, 9) == 0);
        i.ms  = ($urandom_range(0, 6) == 0);
        return i;
    endfunction

    // Helper: a valid instruction with the given indices and load/write flags.
    function automatic in_t instr(input int rs, input int rt, input int rd,
                                  input logic urs, input logic urt, input logic mr);
        in_t i;
        i = idle_in();
        i.v = 1'b1; i.rs = RB'(rs); i.rt = RB'(rt); i.rd = RB'(rd);
        i.urs = urs; i.urt = urt; i.mr = mr; i.rw = 1'b1; i.m2r = mr;
        return i;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        m = mdl_zero();
        #1 chk_all("reset_async");
        chk("reset_async.hz_stall", 32'(hz_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[14];
    logic hz;
    logic [RB-1:0] frz_rd;
    logic [CW-1:0] frz_cnt;

    initial begin
        cur   = idle_in();
        m     = mdl_zero();
        rst_n = 1'b0;
        #17 rst_n = 1'b1;

        // Reset asserted mid-cycle while EX holds a valid instruction, then first capture.
        cur = instr(1, 2, 7, 1'b1, 1'b0, 1'b0);
        step("pre_reset", hz);
        chk("pre_reset.ex_valid_set", 32'(ex_valid), 32'd1);
        do_reset();
        cur = instr(0, 0, 5, 1'b0, 1'b0, 1'b0);
        step("first_capture", hz);
        chk("first_capture.ex_rd", 32'(ex_rd), 32'd5);
        chk("first_capture.ex_reg_write", 32'(ex_reg_write), 32'd1);

        // Directed table: load-use, r0/unused-operand no-stall, flush priority, mem_stall hold.
        do_reset();
        //         v  rs  rt  rd urs urt mr rw fl ms  hz  v  rd rw cnt
        tbl[0]  = '{1, 1,  0,  8, 1, 0, 1, 1, 0, 0,  0, 1,  8, 1, 0};
        tbl[1]  = '{1, 8,  2,  9, 1, 0, 0, 1, 0, 0,  1, 0,  0, 0, 1};
        tbl[2]  = '{1, 8,  2,  9, 1, 0, 0, 1, 0, 0,  0, 1,  9, 1, 1};
        tbl[3]  = '{1, 0,  0,  0, 1, 0, 1, 1, 0, 0,  0, 1,  0, 0, 1};
        tbl[4]  = '{1, 0,  0,  4, 1, 0, 0, 1, 0, 0,  0, 1,  4, 1, 1};
        tbl[5]  = '{1, 1,  0,  8, 1, 0, 1, 1, 0, 0,  0, 1,  8, 1, 1};
        tbl[6]  = '{1, 2,  8,  5, 1, 0, 0, 1, 0, 0,  0, 1,  5, 1, 1};
        tbl[7]  = '{1, 1,  0,  3, 1, 0, 1, 1, 0, 0,  0, 1,  3, 1, 1};
        tbl[8]  = '{1, 3,  0,  6, 1, 0, 0, 1, 1, 0,  0, 0,  0, 0, 1};
        tbl[9]  = '{0, 1,  2,  7, 1, 1, 0, 1, 0, 0,  0, 0,  7, 0, 1};
        tbl[10] = '{1, 1,  0, 10, 1, 0, 1, 1, 0, 0,  0, 1, 10, 1, 1};
        tbl[11] = '{1, 2, 10, 11, 0, 1, 0, 1, 0, 1,  0, 1, 10, 1, 1};
        tbl[12] = '{1, 2, 10, 11, 0, 1, 0, 1, 0, 0,  1, 0,  0, 0, 2};
        tbl[13] = '{1, 2, 10, 11, 0, 1, 0, 1, 0, 0,  0, 1, 11, 1, 2};
        for (int k = 0; k < 14; k++) begin
            cur     = idle_in();
            cur.v   = tbl[k].v;   cur.rs  = tbl[k].rs;  cur.rt = tbl[k].rt; cur.rd = tbl[k].rd;
            cur.urs = tbl[k].urs; cur.urt = tbl[k].urt; cur.mr = tbl[k].mr; cur.rw = tbl[k].rw;
            cur.fl  = tbl[k].fl;  cur.ms  = tbl[k].ms;
            step($sformatf("tbl%0d", k), hz);
            chk($sformatf("tbl%0d.hz", k),  32'(hz),           32'(tbl[k].e_hz));
            chk($sformatf("tbl%0d.v", k),   32'(ex_valid),     32'(tbl[k].e_v));
            chk($sformatf("tbl%0d.rd", k),  32'(ex_rd),        32'(tbl[k].e_rd));
            chk($sformatf("tbl%0d.rw", k),  32'(ex_reg_write), 32'(tbl[k].e_rw));
            chk($sformatf("tbl%0d.cnt", k), 32'(stall_cnt),    32'(tbl[k].e_cnt));
        end

        // mem_stall held for three cycles with a pending load-use and changing ID.
        do_reset();
        cur = instr(1, 0, 12, 1'b1, 1'b0, 1'b1);
        step("ms_load", hz);
        frz_rd  = ex_rd;
        frz_cnt = stall_cnt;
        for (int k = 0; k < 3; k++) begin
            cur    = instr(12, $urandom_range(0, 31), $urandom_range(1, 31), 1'b1, 1'b0, 1'b0);
            cur.ms = 1'b1;
            step($sformatf("ms_hold%0d", k), hz);
            chk($sformatf("ms_hold%0d.hz", k),  32'(hz),        32'd0);
            chk($sformatf("ms_hold%0d.rd", k),  32'(ex_rd),     32'd12);
            chk($sformatf("ms_hold%0d.cnt", k), 32'(stall_cnt), 32'(frz_cnt));
        end
        cur.ms = 1'b0;
        step("ms_release", hz);
        chk("ms_release.hz", 32'(hz), 32'd1);
        chk("ms_release.cnt", 32'(stall_cnt), 32'd1);

        // Saturation of the 2-bit counter over five load-use events.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cur = instr(1, 0, 12, 1'b1, 1'b0, 1'b1);
            step($sformatf("sat_ld%0d", k), hz);
            cur = instr(4, 12, 13, 1'b0, 1'b1, 1'b0);
            step($sformatf("sat_dep%0d", k), hz);
            chk($sformatf("sat%0d.cnt", k), 32'(stall_cnt), 32'((k + 1 > 3) ? 3 : k + 1));
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cur = rand_in();
            step("rand", hz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
